// File: rtl/pre_neuron_sched.sv
// pre_neuron_sched: sequences the pre-synaptic spike-history SRAM through the
// combinational pre_neuron update datapath.
//
// Work selection in IDLE is ref sweep > time-step advance > spike. A spike
// runs a read-modify-write (IDLE read, RD update, WB write). A reference
// request sweeps every entry to zero, one write per cycle.
//
// Optional feature macro: PRE_SCHED_WR_SKIP_EN. When defined, a spike whose
// updated word equals the word read skips the write-back.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   spk_valid/addr/ready  spike request handshake from the input router
//   step_done             pulse: advance the time step
//   ref_start / ref_done  pulse: start clear sweep / pulse: sweep complete
//   busy                  FSM not idle or a step/ref request pending
//   current_time_step     time step to pre_neuron
//   sram_*                single-port SRAM master (read data one cycle later)
//   pre_spike_cnt, neuron_event, neuron_event_pulse, time_ref_event,
//   pre_spike_cnt_next    pre_neuron datapath controls and result
//
// TIME_STEP must be at least 2 and at most PRE_NEUR_SPIKE_CNT_WIDTH.
module pre_neuron_sched #(
  parameter int unsigned N_PRE                    = 256,
  parameter int unsigned PRE_NEUR_SPIKE_CNT_WIDTH = 8,
  parameter int unsigned TIME_STEP                = 8
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                spk_valid,
  input  logic [$clog2(N_PRE)-1:0]            spk_addr,
  output logic                                spk_ready,
  input  logic                                step_done,
  input  logic                                ref_start,
  output logic                                ref_done,
  output logic                                busy,
  output logic [$clog2(TIME_STEP)-1:0]        current_time_step,
  output logic                                sram_cs,
  output logic                                sram_we,
  output logic [$clog2(N_PRE)-1:0]            sram_addr,
  output logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_wdata,
  input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_rdata,
  output logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] pre_spike_cnt,
  output logic                                neuron_event,
  output logic                                neuron_event_pulse,
  output logic                                time_ref_event,
  input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] pre_spike_cnt_next
);

  localparam int unsigned AW  = $clog2(N_PRE);
  localparam int unsigned TSW = $clog2(TIME_STEP);
  localparam int unsigned W   = PRE_NEUR_SPIKE_CNT_WIDTH;

  typedef enum logic [1:0] {StIdle, StRd, StWb, StClr} state_e;

  state_e         state_q, state_d;
  logic           ref_pend_q, ref_pend_d;
  logic           step_pend_q, step_pend_d;
  logic           ref_done_q, ref_done_d;
  logic [TSW-1:0] step_q, step_d;
  // Latched spike address, reused as the sweep address during CLR.
  logic [AW-1:0]  addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      ref_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      ref_done_q  <= 1'b0;
      step_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ref_pend_q  <= ref_pend_d;
      step_pend_q <= step_pend_d;
      ref_done_q  <= ref_done_d;
      step_q      <= step_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    ref_pend_d         = ref_pend_q;
    step_pend_d        = step_pend_q;
    ref_done_d         = 1'b0;
    step_d             = step_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    spk_ready          = 1'b0;
    sram_cs            = 1'b0;
    sram_we            = 1'b0;
    sram_addr          = '0;
    sram_wdata         = '0;
    pre_spike_cnt      = '0;
    neuron_event       = 1'b0;
    neuron_event_pulse = 1'b0;
    time_ref_event     = 1'b0;

    // Pulses are captured in every state; a second ref request while one is
    // pending or sweeping is redundant and dropped.
    if (step_done) step_pend_d = 1'b1;
    if (ref_start && (state_q != StClr) && !ref_pend_q) ref_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (ref_pend_q) begin
          ref_pend_d = 1'b0;
          addr_d     = '0;
          state_d    = StClr;
        end else if (step_pend_q) begin
          step_d      = (step_q == TSW'(TIME_STEP - 1)) ? '0 : step_q + 1'b1;
          // A fresh pulse in this same cycle stays pending.
          step_pend_d = step_done;
        end else begin
          spk_ready = 1'b1;
          if (spk_valid) begin
            sram_cs   = 1'b1;
            sram_addr = spk_addr;
            addr_d    = spk_addr;
            state_d   = StRd;
          end
        end
      end
      StRd: begin
        pre_spike_cnt      = sram_rdata;
        neuron_event       = 1'b1;
        neuron_event_pulse = 1'b1;
        wdata_d            = pre_spike_cnt_next;
`ifdef PRE_SCHED_WR_SKIP_EN
        state_d = (pre_spike_cnt_next == sram_rdata) ? StIdle : StWb;
`else
        state_d = StWb;
`endif
      end
      StWb: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        state_d    = StIdle;
      end
      StClr: begin
        time_ref_event = 1'b1;
        sram_cs        = 1'b1;
        sram_we        = 1'b1;
        sram_addr      = addr_q;
        sram_wdata     = pre_spike_cnt_next;
        // Steps are meaningless across a reference reset: drop them.
        step_pend_d    = 1'b0;
        addr_d         = addr_q + 1'b1;
        if (addr_q == AW'(N_PRE - 1)) begin
          step_d     = '0;
          addr_d     = '0;
          ref_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ref_done          = ref_done_q;
  assign current_time_step = step_q;
  assign busy              = (state_q != StIdle) || ref_pend_q || step_pend_q;

endmodule

// File: tb/tb_pre_neuron_sched.sv
module tb_pre_neuron_sched;

  localparam int unsigned N_PRE = 256;
  localparam int unsigned W     = 8;
  localparam int unsigned TS    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned TSW   = 3;
  localparam int unsigned VW    = 5 + AW + 2 * W + 3 + TSW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          spk_valid = 1'b0;
  logic [AW-1:0] spk_addr = '0;
  logic          spk_ready;
  logic          step_done = 1'b0;
  logic          ref_start = 1'b0;
  logic          ref_done, busy;
  logic [TSW-1:0] current_time_step;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_wdata, sram_rdata, pre_spike_cnt, pre_spike_cnt_next;
  logic          neuron_event, neuron_event_pulse, time_ref_event;

  int tests_run = 0;
  int tests_failed = 0;

  pre_neuron_sched #(
    .N_PRE                    (N_PRE),
    .PRE_NEUR_SPIKE_CNT_WIDTH (W),
    .TIME_STEP                (TS)
  ) dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .spk_valid          (spk_valid),
    .spk_addr           (spk_addr),
    .spk_ready          (spk_ready),
    .step_done          (step_done),
    .ref_start          (ref_start),
    .ref_done           (ref_done),
    .busy               (busy),
    .current_time_step  (current_time_step),
    .sram_cs            (sram_cs),
    .sram_we            (sram_we),
    .sram_addr          (sram_addr),
    .sram_wdata         (sram_wdata),
    .sram_rdata         (sram_rdata),
    .pre_spike_cnt      (pre_spike_cnt),
    .neuron_event       (neuron_event),
    .neuron_event_pulse (neuron_event_pulse),
    .time_ref_event     (time_ref_event),
    .pre_spike_cnt_next (pre_spike_cnt_next)
  );

  always #5 CLK = ~CLK;

  // pre_neuron datapath model: set the current step bit, or clear on a ref.
  logic [W-1:0] step_bit;
  always_comb begin
    step_bit = '0;
    step_bit[current_time_step] = 1'b1;
    if (time_ref_event) pre_spike_cnt_next = '0;
    else if (neuron_event) pre_spike_cnt_next = pre_spike_cnt | step_bit;
    else pre_spike_cnt_next = pre_spike_cnt;
  end

  // SRAM model plus write / ref_done monitor.
  logic [W-1:0] mem [N_PRE];
  logic [W-1:0] rdata_r = '0;
  assign sram_rdata = rdata_r;
  int cyc = 0;
  int last_wr_cyc = 0;
  int ref_done_cyc = 0;
  int ref_done_cnt = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [W-1:0]  wr_data_q [$];

  always @(posedge CLK) begin
    if (sram_cs && !sram_we) rdata_r <= mem[sram_addr];
    if (sram_cs && sram_we) begin
      mem[sram_addr] <= sram_wdata;
      wr_addr_q.push_back(sram_addr);
      wr_data_q.push_back(sram_wdata);
      last_wr_cyc = cyc;
    end
    if (ref_done) begin
      ref_done_cnt++;
      ref_done_cyc = cyc;
    end
    cyc++;
  end

  // Reset-value vector; spk_ready is the only bit that resets high.
  logic [VW-1:0] outs_vec;
  assign outs_vec = {spk_ready, busy, ref_done, sram_cs, sram_we, sram_addr, sram_wdata,
                     pre_spike_cnt, neuron_event, neuron_event_pulse, time_ref_event,
                     current_time_step};
  localparam logic [VW-1:0] ResetVec = {1'b1, {(VW - 1){1'b0}}};

  task automatic pulse_step();
    @(negedge CLK); step_done = 1'b1;
    @(negedge CLK); step_done = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_spike(input logic [AW-1:0] a, output int hs);
    int n;
    n = 0;
    @(negedge CLK); spk_valid = 1'b1; spk_addr = a; #1;
    while (!spk_ready && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    tests_run++;
    if (!spk_ready) begin
      tests_failed++;
      $display("FAIL spike_wait: spk_ready=%b required 1 within 20 cycles", spk_ready);
    end
    hs = cyc;
    @(negedge CLK); spk_valid = 1'b0;
  endtask

  task automatic wait_ref_done(input string name);
    int n;
    n = 0;
    while (!ref_done && n < 400) begin
      @(negedge CLK); #1; n++;
    end
    tests_run++;
    if (!ref_done) begin
      tests_failed++;
      $display("FAIL %s: ref_done=%b required 1 within 400 cycles", name, ref_done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_PRE; i++) mem[i] = W'(i * 7 + 1);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    tests_run++;
    if (outs_vec !== ResetVec) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h required %h", outs_vec, ResetVec);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_spike_basic();
    mem[5] = 8'h00;
    wr_addr_q.delete(); wr_data_q.delete();
    @(negedge CLK); spk_valid = 1'b1; spk_addr = 8'd5; #1;
    tests_run++;
    if ({spk_ready, sram_cs, sram_we, sram_addr} !== {1'b1, 1'b1, 1'b0, 8'd5}) begin
      tests_failed++;
      $display("FAIL spike_read: rdy/cs/we/addr=%b%b%b/%0d required 110/5",
               spk_ready, sram_cs, sram_we, sram_addr);
    end
    @(negedge CLK); spk_valid = 1'b0; #1;
    tests_run++;
    if ({spk_ready, neuron_event, neuron_event_pulse, sram_cs, pre_spike_cnt} !==
        {4'b0110, 8'h00}) begin
      tests_failed++;
      $display("FAIL spike_rd: rdy/ev/pulse/cs=%b%b%b%b cnt=%h required 0110 00",
               spk_ready, neuron_event, neuron_event_pulse, sram_cs, pre_spike_cnt);
    end
    @(negedge CLK); #1;
    tests_run++;
    if ({spk_ready, sram_cs, sram_we, sram_addr, sram_wdata} !== {3'b011, 8'd5, 8'h01}) begin
      tests_failed++;
      $display("FAIL spike_wb: rdy/cs/we=%b%b%b addr=%0d data=%h required 011 5 01",
               spk_ready, sram_cs, sram_we, sram_addr, sram_wdata);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (spk_ready !== 1'b1 || wr_addr_q.size() != 1 || mem[5] !== 8'h01) begin
      tests_failed++;
      $display("FAIL spike_done: rdy=%b writes=%0d mem5=%h required 1 1 01",
               spk_ready, wr_addr_q.size(), mem[5]);
    end
  endtask

  task automatic test_step();
    int hs;
    @(negedge CLK); step_done = 1'b1;
    @(negedge CLK); step_done = 1'b0; #1;
    tests_run++;
    if (busy !== 1'b1 || spk_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_pending: busy=%b rdy=%b required 1 0", busy, spk_ready);
    end
    @(negedge CLK);
    pulse_step(); pulse_step();
    tests_run++;
    if (current_time_step !== 3'd3) begin
      tests_failed++;
      $display("FAIL step_count: step=%0d required 3", current_time_step);
    end
    mem[7] = 8'h01;
    wr_addr_q.delete(); wr_data_q.delete();
    do_spike(8'd7, hs);
    repeat (3) @(negedge CLK);
    tests_run++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'd7 || wr_data_q[0] !== 8'h09) begin
      tests_failed++;
      $display("FAIL step_spike: writes=%0d mem7=%h required 1 write of 09", wr_addr_q.size(),
               mem[7]);
    end
    repeat (4) pulse_step();
    tests_run++;
    if (current_time_step !== 3'd7) begin
      tests_failed++;
      $display("FAIL step_max: step=%0d required 7", current_time_step);
    end
    pulse_step();
    tests_run++;
    if (current_time_step !== 3'd0) begin
      tests_failed++;
      $display("FAIL step_wrap: step=%0d required 0", current_time_step);
    end
  endtask

  task automatic test_sweep();
    int bad, not_ready_viol;
    pulse_step(); pulse_step();
    wr_addr_q.delete(); wr_data_q.delete();
    ref_done_cnt = 0;
    not_ready_viol = 0;
    @(negedge CLK); ref_start = 1'b1;
    @(negedge CLK); ref_start = 1'b0; #1;
    for (int n = 0; n < 400 && !ref_done; n++) begin
      if (spk_ready !== 1'b0) not_ready_viol++;
      @(negedge CLK); #1;
    end
    tests_run++;
    if (!ref_done || not_ready_viol != 0) begin
      tests_failed++;
      $display("FAIL sweep_ready: ref_done=%b ready_high_cycles=%0d required 1 0",
               ref_done, not_ready_viol);
    end
    repeat (3) @(negedge CLK);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== 8'h00) bad++;
    tests_run++;
    if (wr_addr_q.size() != N_PRE || bad != 0) begin
      tests_failed++;
      $display("FAIL sweep_writes: writes=%0d bad=%0d required 256 0", wr_addr_q.size(), bad);
    end
    tests_run++;
    if (ref_done_cnt != 1 || ref_done_cyc != last_wr_cyc + 1) begin
      tests_failed++;
      $display("FAIL sweep_done: pulses=%0d lag=%0d required 1 1", ref_done_cnt,
               ref_done_cyc - last_wr_cyc);
    end
    tests_run++;
    if (current_time_step !== 3'd0 || mem[200] !== 8'h00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_state: step=%0d mem200=%h busy=%b required 0 00 0",
               current_time_step, mem[200], busy);
    end
  endtask

  task automatic test_step_ref_simul();
    repeat (4) pulse_step();
    wr_addr_q.delete(); wr_data_q.delete();
    @(negedge CLK); step_done = 1'b1; ref_start = 1'b1;
    @(negedge CLK); step_done = 1'b0; ref_start = 1'b0; #1;
    wait_ref_done("simul_wait");
    repeat (3) @(negedge CLK);
    tests_run++;
    if (current_time_step !== 3'd0 || wr_addr_q.size() != N_PRE) begin
      tests_failed++;
      $display("FAIL simul_step_ref: step=%0d writes=%0d required 0 256",
               current_time_step, wr_addr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int hs0, hs1, exp_gap, exp_wr;
`ifdef PRE_SCHED_WR_SKIP_EN
    exp_gap = 2; exp_wr = 1;
`else
    exp_gap = 3; exp_wr = 2;
`endif
    pulse_step(); pulse_step();
    mem[3] = 8'h00;
    wr_addr_q.delete(); wr_data_q.delete();
    do_spike(8'd3, hs0);
    do_spike(8'd3, hs1);
    repeat (3) @(negedge CLK);
    tests_run++;
    if (hs1 - hs0 != exp_gap) begin
      tests_failed++;
      $display("FAIL dup_gap: gap=%0d required %0d", hs1 - hs0, exp_gap);
    end
    tests_run++;
    if (wr_addr_q.size() != exp_wr || wr_data_q[0] !== 8'h04 ||
        wr_data_q[wr_addr_q.size() - 1] !== 8'h04 || mem[3] !== 8'h04) begin
      tests_failed++;
      $display("FAIL dup_writes: writes=%0d mem3=%h required %0d 04", wr_addr_q.size(),
               mem[3], exp_wr);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    ref_done_cnt = 0;
    @(negedge CLK); ref_start = 1'b1;
    @(negedge CLK); ref_start = 1'b0; #1;
    while (!(time_ref_event && sram_addr == 8'd100) && n < 200) begin
      @(negedge CLK); #1; n++;
    end
    tests_run++;
    if (!(time_ref_event && sram_addr == 8'd100)) begin
      tests_failed++;
      $display("FAIL midreset_reach: addr=%0d required 100 within 200 cycles", sram_addr);
    end
    RST_N = 1'b0; #1;
    tests_run++;
    if (outs_vec !== ResetVec) begin
      tests_failed++;
      $display("FAIL midreset_async: got %h required %h", outs_vec, ResetVec);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    tests_run++;
    if (ref_done_cnt != 0 || spk_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_after: ref_done_pulses=%0d rdy=%b busy=%b required 0 1 0",
               ref_done_cnt, spk_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_spike_basic();
    test_step();
    test_sweep();
    test_step_ref_simul();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
